// File: rtl/biphasemark_encode_if.sv
// Sample handshake bundle between the audio source and the biphase-mark encoder.
interface biphasemark_encode_if;
  logic [19:0] sample_in;
  logic [3:0]  aux_in;
  logic        invalid_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_in, aux_in, invalid_in, sample_valid, input sample_ready);
  modport slave  (input sample_in, aux_in, invalid_in, sample_valid, output sample_ready);
endinterface

// File: rtl/biphasemark_encode.sv
// Biphase-mark subframe encoder: builds 32-slot subframes (preamble, aux, audio,
// V, U, C, P) from a one-entry holding register and serialises them as cells.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | line held at 0, waiting for en
// PREAMBLE | cells 0-7, Z/X/Y pattern; cell 0 unloads the holding register
// PAYLOAD  | cells 8-63, biphase-mark coding of slots 4-31
module biphasemark_encode #(
  parameter int HALF_BIT_CLKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  biphasemark_encode_if.slave smp,
  input  logic [191:0]        channel_status,
  output logic                dout,
  output logic                cell_strobe,
  output logic [7:0]          frame_counter,
  output logic                channel,
  output logic                block_start,
  output logic                underrun
);

  localparam int DW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(HALF_BIT_CLKS - 1);
  localparam logic [7:0] PRE_Z = 8'hE8;
  localparam logic [7:0] PRE_X = 8'hE2;
  localparam logic [7:0] PRE_Y = 8'hE4;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cell_q, cell_d;
  logic [DW-1:0]  div_q, div_d;
  logic [7:0]     frame_q, frame_d;
  logic           chan_q, chan_d;
  logic           lvl_q, lvl_d;
  logic [7:0]     pre_q, pre_d;          // preamble already adjusted for prior level
  logic [27:0]    word_q, word_d;        // slots 4..31, bit 0 = slot 4
  logic [191:0]   cs_q, cs_d;
  logic           hold_full_q, hold_full_d;
  logic [19:0]    hold_smp_q, hold_smp_d;
  logic [3:0]     hold_aux_q, hold_aux_d;
  logic           hold_inv_q, hold_inv_d;
  logic           dout_q, dout_d;
  logic           strobe_q, strobe_d;
  logic [7:0]     frame_out_q, frame_out_d;
  logic           chan_out_q, chan_out_d;
  logic           bs_q, bs_d;
  logic           ur_q, ur_d;

  logic        first_cyc;
  logic        load;
  logic        cs_bit;
  logic [19:0] tx_smp;
  logic [3:0]  tx_aux;
  logic        tx_inv;
  logic [7:0]  pre_sel;
  logic [4:0]  slot_idx;

  assign first_cyc = (state_q == PREAMBLE) && (cell_q == 6'd0) && (div_q == DIV_LOAD);
  assign smp.sample_ready = !hold_full_q || first_cyc;
  assign load = smp.sample_valid && smp.sample_ready;

  // Holding register and subframe word assembly at the start of each subframe
  always_comb begin
    hold_full_d = hold_full_q;
    hold_smp_d  = hold_smp_q;
    hold_aux_d  = hold_aux_q;
    hold_inv_d  = hold_inv_q;
    word_d      = word_q;
    cs_d        = cs_q;
    cs_bit      = 1'b0;
    tx_smp      = hold_full_q ? hold_smp_q : 20'd0;
    tx_aux      = hold_full_q ? hold_aux_q : 4'd0;
    tx_inv      = hold_full_q ? hold_inv_q : 1'b1;
    if (first_cyc) begin
      hold_full_d = 1'b0;
      // A Z subframe uses the status word arriving this cycle, not the stale copy.
      if (frame_q == 8'd0 && !chan_q) begin
        cs_d   = channel_status;
        cs_bit = channel_status[frame_q];
      end else begin
        cs_bit = cs_q[frame_q];
      end
      word_d = {^{cs_bit, tx_inv, tx_smp, tx_aux}, cs_bit, 1'b0, tx_inv, tx_smp, tx_aux};
    end
    if (load) begin
      hold_full_d = 1'b1;
      hold_smp_d  = smp.sample_in;
      hold_aux_d  = smp.aux_in;
      hold_inv_d  = smp.invalid_in;
    end
  end

  // Cell sequencing, channel/frame bookkeeping and line-level generation
  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    div_d    = div_q;
    frame_d  = frame_q;
    chan_d   = chan_q;
    lvl_d    = lvl_q;
    pre_d    = pre_q;
    pre_sel  = PRE_Z;
    slot_idx = cell_q[5:1] - 5'd4;
    case (state_q)
      IDLE: begin
        lvl_d   = 1'b0;
        frame_d = 8'd0;
        chan_d  = 1'b0;
        if (en) begin
          state_d = PREAMBLE;
          cell_d  = 6'd0;
          div_d   = DIV_LOAD;
          pre_d   = PRE_Z;
          lvl_d   = PRE_Z[7];
        end
      end
      PREAMBLE, PAYLOAD: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_LOAD;
          if (cell_q == 6'd63) begin
            if (chan_q && !en) begin
              state_d = IDLE;
              frame_d = 8'd0;
              chan_d  = 1'b0;
              lvl_d   = 1'b0;
            end else begin
              chan_d  = !chan_q;
              frame_d = chan_q ? ((frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1) : frame_q;
              if (!chan_q)             pre_sel = PRE_Y;
              else if (frame_d == 8'd0) pre_sel = PRE_Z;
              else                     pre_sel = PRE_X;
              pre_d   = pre_sel ^ {8{lvl_q}};
              lvl_d   = pre_d[7];
              cell_d  = 6'd0;
              state_d = PREAMBLE;
            end
          end else begin
            cell_d = cell_q + 6'd1;
            if (cell_q < 6'd7) begin
              lvl_d = pre_q[3'd6 - cell_q[2:0]];
            end else begin
              state_d = PAYLOAD;
              // Even cells open a slot (always toggle); odd cells toggle for a 1.
              if (!cell_d[0]) lvl_d = !lvl_q;
              else            lvl_d = lvl_q ^ word_q[slot_idx];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered line outputs, one cycle behind the sequencer
  always_comb begin
    dout_d      = (state_q != IDLE) && lvl_q;
    strobe_d    = (state_q != IDLE) && (div_q == DIV_LOAD);
    frame_out_d = frame_q;
    chan_out_d  = chan_q;
    bs_d        = first_cyc && (frame_q == 8'd0) && !chan_q;
    ur_d        = first_cyc && !hold_full_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cell_q      <= 6'd0;
      div_q       <= '0;
      frame_q     <= 8'd0;
      chan_q      <= 1'b0;
      lvl_q       <= 1'b0;
      pre_q       <= 8'd0;
      word_q      <= 28'd0;
      cs_q        <= 192'd0;
      hold_full_q <= 1'b0;
      hold_smp_q  <= 20'd0;
      hold_aux_q  <= 4'd0;
      hold_inv_q  <= 1'b0;
      dout_q      <= 1'b0;
      strobe_q    <= 1'b0;
      frame_out_q <= 8'd0;
      chan_out_q  <= 1'b0;
      bs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
      chan_q      <= chan_d;
      lvl_q       <= lvl_d;
      pre_q       <= pre_d;
      word_q      <= word_d;
      cs_q        <= cs_d;
      hold_full_q <= hold_full_d;
      hold_smp_q  <= hold_smp_d;
      hold_aux_q  <= hold_aux_d;
      hold_inv_q  <= hold_inv_d;
      dout_q      <= dout_d;
      strobe_q    <= strobe_d;
      frame_out_q <= frame_out_d;
      chan_out_q  <= chan_out_d;
      bs_q        <= bs_d;
      ur_q        <= ur_d;
    end
  end

  assign dout          = dout_q;
  assign cell_strobe   = strobe_q;
  assign frame_counter = frame_out_q;
  assign channel       = chan_out_q;
  assign block_start   = bs_q;
  assign underrun      = ur_q;

endmodule

// File: tb/tb_biphasemark_encode.sv
// Bench for biphasemark_encode: table vectors, directed corner sequences and
// random traffic checked against a subframe-level reference model.
module tb_biphasemark_encode;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [191:0] channel_status = '0;
  logic         dout, cell_strobe, channel, block_start, underrun;
  logic [7:0]   frame_counter;

  biphasemark_encode_if sif ();

  biphasemark_encode #(.HALF_BIT_CLKS(H)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .smp(sif.slave),
    .channel_status(channel_status), .dout(dout), .cell_strobe(cell_strobe),
    .frame_counter(frame_counter), .channel(channel),
    .block_start(block_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] cells;
    logic [7:0]  frame;
    logic        chan;
    logic        ur;
  } exp_t;

  typedef struct {
    logic [63:0] cells;
    logic [7:0]  frame;
    logic        chan;
    logic        bs;
    logic        ur;
  } cap_t;

  exp_t expq[$];
  cap_t cap_q[$];

  logic         m_active, m_full, m_prior;
  int           m_next, m_sf;
  logic [19:0]  m_s;
  logic [3:0]   m_a;
  logic         m_v;
  logic [191:0] m_cs;

  task automatic model_reset();
    m_active = 0; m_full = 0; m_prior = 0; m_next = 0; m_sf = 0; m_cs = '0;
    expq.delete();
  endtask

  function automatic logic slot_val(input int s, input logic [3:0] a, input logic [19:0] smp,
                                    input logic v, input logic cb);
    logic p;
    p = logic'(($countones(a) + $countones(smp) + int'(v) + int'(cb)) % 2);
    if (s < 8)       return a[s-4];
    else if (s < 28) return smp[s-8];
    else if (s == 28) return v;
    else if (s == 29) return 1'b0;
    else if (s == 30) return cb;
    else             return p;
  endfunction

  function automatic logic [63:0] build(input logic [7:0] pre, input logic prior,
                                        input logic [3:0] a, input logic [19:0] smp,
                                        input logic v, input logic cb, output logic end_lvl);
    logic [63:0] c;
    logic lv;
    c = '0;
    for (int k = 0; k < 8; k++) c[63-k] = pre[7-k] ^ prior;
    lv = c[56];
    for (int s = 4; s < 32; s++) begin
      lv = ~lv;
      c[63-2*s] = lv;
      if (slot_val(s, a, smp, v, cb)) lv = ~lv;
      c[62-2*s] = lv;
    end
    end_lvl = lv;
    return c;
  endfunction

  // Evaluates the coming rising edge using the inputs currently driven.
  task automatic model_tick();
    int p;
    logic unload, exp_rdy, fire, cb, endl;
    logic [19:0] s; logic [3:0] a; logic v; logic [7:0] pre;
    exp_t e;
    p = cyc;
    unload = m_active && (p == m_next);
    exp_rdy = !m_full || unload;
    chk("sample_ready", sample_ready_w, exp_rdy);
    fire = sif.sample_valid && exp_rdy;
    if (unload) begin
      if (m_full) begin s = m_s; a = m_a; v = m_v; end
      else begin s = 0; a = 0; v = 1; end
      e.frame = 8'((m_sf / 2) % 192);
      e.chan  = logic'(m_sf % 2);
      e.ur    = !m_full;
      if (e.frame == 0 && !e.chan) m_cs = channel_status;
      cb = m_cs[e.frame];
      pre = e.chan ? 8'hE4 : (e.frame == 0 ? 8'hE8 : 8'hE2);
      e.cells = build(pre, m_prior, a, s, v, cb, endl);
      m_prior = endl;
      expq.push_back(e);
      m_sf++;
      m_next += 64 * H;
      m_full = 0;
    end
    if (fire) begin
      m_full = 1; m_s = sif.sample_in; m_a = sif.aux_in; m_v = sif.invalid_in;
    end
    if (!m_active) begin
      if (en) begin m_active = 1; m_next = p + 1; m_sf = 0; m_prior = 0; end
    end else if (p == m_next - 1 && m_sf >= 2 && (m_sf % 2) == 0 && !en) begin
      m_active = 0;
    end
  endtask

  logic sample_ready_w;
  assign sample_ready_w = sif.sample_ready;

  // ---------------- line monitor ----------------
  int          mcnt = 0;
  int          last_strobe = 0;
  int          bs_count = 0;
  logic        cur_lvl;
  logic [63:0] mcells;
  cap_t        mrec;

  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
    end else begin
      if (cell_strobe) begin
        if (block_start) bs_count++;
        if (mcnt == 0) begin
          mrec.frame = frame_counter; mrec.chan = channel;
          mrec.bs = block_start; mrec.ur = underrun;
        end else begin
          chk("cell_len", 64'(cyc - last_strobe), 64'(H));
          chk("frame_hold", 64'(frame_counter), 64'(mrec.frame));
          chk("chan_hold", 64'(channel), 64'(mrec.chan));
          chk("pulse_len", 64'(block_start | underrun), 64'd0);
        end
        last_strobe = cyc;
        cur_lvl = dout;
        mcells = {mcells[62:0], dout};
        mcnt++;
        if (mcnt == 64) begin
          exp_t e;
          mcnt = 0;
          mrec.cells = mcells;
          cap_q.push_back(mrec);
          if (expq.size() == 0) begin
            chk("subframe_unexpected", 64'd1, 64'd0);
          end else begin
            e = expq.pop_front();
            chk("sf_cells", mrec.cells, e.cells);
            chk("sf_frame", 64'(mrec.frame), 64'(e.frame));
            chk("sf_chan", 64'(mrec.chan), 64'(e.chan));
            chk("sf_underrun", 64'(mrec.ur), 64'(e.ur));
            chk("sf_block_start", 64'(mrec.bs), 64'(e.frame == 0 && !e.chan));
          end
        end
      end else if (mcnt != 0) begin
        chk("cell_stable", 64'(dout), 64'(cur_lvl));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      model_tick();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
    chk({tag, "_strobe"}, 64'(cell_strobe), 64'd0);
    chk({tag, "_ready"}, 64'(sif.sample_ready), 64'd1);
    chk({tag, "_frame"}, 64'(frame_counter), 64'd0);
    chk({tag, "_chan"}, 64'(channel), 64'd0);
    chk({tag, "_bs"}, 64'(block_start), 64'd0);
    chk({tag, "_ur"}, 64'(underrun), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals(tag);
    model_reset();
    cap_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_caps(input string nm, input int n, input int budget);
    int b = 0;
    while (cap_q.size() < n && b < budget) begin
      step(1);
      b++;
    end
    chk(nm, 64'(cap_q.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic [19:0] s;
    logic [3:0]  a;
    logic        v;
    logic        cs0;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{20'hFFFFF, 4'h0, 1'b0, 1'b0, 64'hE8CC_AAAA_AAAA_AACC, 64'hE4CC_AAAA_AAAA_AACC};
    tbl[1] = '{20'hFFFFF, 4'h0, 1'b0, 1'b1, 64'hE8CC_AAAA_AAAA_AACA, 64'hE4CC_AAAA_AAAA_AACA};
    tbl[2] = '{20'h00000, 4'h0, 1'b0, 1'b0, 64'hE8CC_CCCC_CCCC_CCCC, 64'hE4CC_CCCC_CCCC_CCCC};
    tbl[3] = '{20'h00000, 4'hF, 1'b0, 1'b0, 64'hE8AA_CCCC_CCCC_CCCC, 64'hE4AA_CCCC_CCCC_CCCC};
    tbl[4] = '{20'h00000, 4'h0, 1'b1, 1'b0, 64'hE8CC_CCCC_CCCC_CCB2, 64'hE4CC_CCCC_CCCC_CCB2};

    sif.sample_valid = 0; sif.sample_in = 0; sif.aux_in = 0; sif.invalid_in = 0;
    model_reset();
    @(negedge clk);
    #1 chk_reset_vals("por");
    rst_n = 1'b1;

    // table-driven constant-sample subframes
    for (int i = 0; i < 5; i++) begin
      en = 0;
      do_reset("rst_tbl");
      channel_status = {191'd0, tbl[i].cs0};
      sif.sample_in = tbl[i].s; sif.aux_in = tbl[i].a; sif.invalid_in = tbl[i].v;
      sif.sample_valid = 1;
      step(3);
      en = 1;
      run_caps("tbl_wait", 3, 3 * 64 * H + 20);
      if (cap_q.size() >= 3) begin
        chk($sformatf("tbl%0d_chA", i), cap_q[0].cells, tbl[i].exp_a);
        chk($sformatf("tbl%0d_chB", i), cap_q[1].cells, tbl[i].exp_b);
        chk($sformatf("tbl%0d_preX", i), 64'(cap_q[2].cells[63:56]), 64'hE2);
      end
    end

    // underrun: one sample only
    en = 0;
    do_reset("rst_ur");
    channel_status = '0;
    sif.sample_in = 20'h12345; sif.aux_in = 4'h6; sif.invalid_in = 0; sif.sample_valid = 1;
    step(1);
    sif.sample_valid = 0;
    step(2);
    en = 1;
    run_caps("ur_wait", 2, 2 * 64 * H + 20);
    if (cap_q.size() >= 2) begin
      chk("ur_first", 64'(cap_q[0].ur), 64'd0);
      chk("ur_second", 64'(cap_q[1].ur), 64'd1);
      chk("ur_cells", cap_q[1].cells, 64'hE4CC_CCCC_CCCC_CCB2);
    end

    // randomized traffic
    en = 0;
    do_reset("rst_rnd");
    channel_status = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    en = 1;
    for (int k = 0; k < 40 * 64 * H; k++) begin
      sif.sample_valid = ($urandom_range(0, 3) != 0);
      sif.sample_in = 20'($urandom);
      sif.aux_in = 4'($urandom_range(0, 15));
      sif.invalid_in = 1'($urandom_range(0, 1));
      if ((k % 700) == 0)
        channel_status = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(1);
    end

    // en dropped in the middle of channel A
    en = 0;
    do_reset("rst_en");
    sif.sample_valid = 1;
    en = 1;
    step(40);
    en = 0;
    step(64 * H * 3);
    chk("en_drop_count", 64'(cap_q.size()), 64'd2);
    chk("en_drop_dout", 64'(dout), 64'd0);
    chk("en_drop_strobe", 64'(cell_strobe), 64'd0);

    // reset in the middle of a channel-B payload
    en = 0;
    do_reset("rst_pre");
    en = 1;
    step(64 * H + 30 * H);
    do_reset("rst_mid");
    run_caps("rst_restart_wait", 1, 64 * H + 20);
    if (cap_q.size() >= 1) begin
      chk("rst_restart_Z", 64'(cap_q[0].cells[63:56]), 64'hE8);
      chk("rst_restart_bs", 64'(cap_q[0].bs), 64'd1);
    end

    // full block: frame wrap and block_start spacing
    en = 0;
    do_reset("rst_blk");
    bs_count = 0;
    en = 1;
    sif.sample_valid = 1;
    for (int k = 0; k < 386 * 64 * H + 40 && cap_q.size() < 386; k++) begin
      sif.sample_in = 20'(m_sf / 2);
      step(1);
    end
    chk("blk_count", 64'(cap_q.size() >= 386), 64'd1);
    chk("blk_bs_pulses", 64'(bs_count), 64'd2);
    if (cap_q.size() >= 386) begin
      chk("blk_frame191", 64'(cap_q[383].frame), 64'd191);
      chk("blk_wrap0", 64'(cap_q[384].frame), 64'd0);
      chk("blk_wrap_Z", 64'(cap_q[384].cells[63:56]), 64'hE8);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
